inv_sbox: RTL and testbench

Inverse-substitution stage for the decryption path. It consumes the byte stream emitted by the chaotic S-box generator, one unique value per accepted beat, and builds the inverse table, with inv[V] = arrival index of V. Once all SIZE entries are loaded, it substitutes cipher-pixel bytes through the inverse table over a valid/ready stream. It sits between the key-schedule/S-box front end and the pixel decryption datapath.

---
 rtl/inv_sbox.sv | 95 +++++++++
 tb/tb_inv_sbox.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox.sv
// Inverse S-box stage: loads a permutation stream into inv[V] = arrival index,
// then substitutes cipher bytes through the inverse table over valid/ready.
module inv_sbox #(
    parameter int SIZE      = 256,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_valid,
    input  logic [BIT_WIDTH-1:0] load_data,
    output logic                 table_ready,
    output logic [BIT_WIDTH:0]   load_count,
    output logic                 dup_err,
    input  logic                 s_valid,
    input  logic [BIT_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [BIT_WIDTH-1:0] m_data,
    input  logic                 m_ready
);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [BIT_WIDTH:0] LAST_COUNT = (BIT_WIDTH + 1)'(SIZE - 1);

    state_t               state;
    logic [BIT_WIDTH-1:0] inv_mem [SIZE];
    logic [SIZE-1:0]      seen;

    logic load_fire;
    logic load_new;
    logic load_dup;
    logic lookup_fire;

    // clear discards any beat offered in the same cycle
    assign load_fire   = (state == ST_LOAD) && load_valid && !clear;
    assign load_new    = load_fire && !seen[load_data];
    assign load_dup    = load_fire && seen[load_data];
    assign s_ready     = table_ready && (!m_valid || m_ready);
    assign lookup_fire = s_valid && s_ready && !clear;

    // NOTE: the table is a register file, not RAM, because reset must zero it;
    // clear leaves it alone since the seen bits already gate reuse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_mem <= '{default: '0};
        end else if (load_new) begin
            inv_mem[load_data] <= load_count[BIT_WIDTH-1:0];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, e.g. load_count is read for the LOAD->RUN test before it increments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            table_ready <= 1'b0;
            load_count  <= '0;
            dup_err     <= 1'b0;
            seen        <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
        end else if (clear) begin
            state       <= ST_LOAD;
            table_ready <= 1'b0;
            load_count  <= '0;
            dup_err     <= 1'b0;
            seen        <= '0;
            m_valid     <= 1'b0;
        end else begin
            if (load_new) begin
                seen[load_data] <= 1'b1;
                load_count      <= load_count + 1'b1;
                if (load_count == LAST_COUNT) begin
                    state       <= ST_RUN;
                    table_ready <= 1'b1;
                end
            end
            if (load_dup) begin
                dup_err <= 1'b1;
            end
            if (lookup_fire) begin
                m_valid <= 1'b1;
                m_data  <= inv_mem[s_data];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inv_sbox.sv
// Self-checking bench for inv_sbox: constant vectors, hand-written corner
// sequences and randomized lookups against a first-arrival inverse model.
module tb_inv_sbox;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load_valid;
    logic [7:0] load_data;
    logic       table_ready;
    logic [8:0] load_count;
    logic       dup_err;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    int checks   = 0;
    int failures = 0;

    // reference model: inverse defined by first arrival of each value
    logic [7:0] model_inv  [N];
    bit         model_seen [N];
    int         model_cnt;
    bit         model_dup;
    logic [7:0] load_q [$];
    logic [7:0] exp_q  [$];
    logic [7:0] perm   [N];

    typedef struct {
        int         kind;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [5];

    inv_sbox #(.SIZE(N), .BIT_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load_valid (load_valid),
        .load_data  (load_data),
        .table_ready(table_ready),
        .load_count (load_count),
        .dup_err    (dup_err),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model_seen[i] = 1'b0;
        model_cnt = 0;
        model_dup = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_table_ready"}, table_ready, 0);
        check({tag, "_load_count"}, load_count, 0);
        check({tag, "_dup_err"}, dup_err, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
    endtask

    // drives load_q one beat per cycle, checking status against the model each beat
    task automatic run_load();
        foreach (load_q[i]) begin
            @(negedge clk);
            check("load_count", load_count, model_cnt);
            check("load_table_ready", table_ready, (model_cnt == N));
            check("load_dup_err", dup_err, model_dup);
            load_valid = 1'b1;
            load_data  = load_q[i];
            if (model_cnt < N) begin
                if (!model_seen[load_q[i]]) begin
                    model_inv[load_q[i]]  = model_cnt[7:0];
                    model_seen[load_q[i]] = 1'b1;
                    model_cnt++;
                end else begin
                    model_dup = 1'b1;
                end
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        check("load_end_count", load_count, model_cnt);
        check("load_end_table_ready", table_ready, (model_cnt == N));
        check("load_end_dup_err", dup_err, model_dup);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic fill_identity();
        load_q.delete();
        for (int i = 0; i < N; i++) load_q.push_back(8'(i));
    endtask

    task automatic fill_reverse();
        load_q.delete();
        for (int i = N - 1; i >= 0; i--) load_q.push_back(8'(i));
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) perm[i] = 8'(i);
        for (int i = N - 1; i > 0; i--) begin
            int         j;
            logic [7:0] t;
            j       = int'($urandom_range(0, i));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        load_q.delete();
        for (int i = 0; i < N; i++) load_q.push_back(perm[i]);
    endtask

    task automatic lookup_one(input string name, input logic [7:0] din, input logic [7:0] exp);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = din;
        m_ready = 1'b1;
        #1;
        check({name, "_s_ready"}, s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        check({name, "_m_valid"}, m_valid, 1);
        check({name, "_m_data"}, m_data, exp);
        @(negedge clk);
        check({name, "_drained"}, m_valid, 0);
    endtask

    // random valid/ready traffic scored against a queue of expected bytes
    task automatic random_stream(input int n);
        int sent = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4 * n + 20 && (sent < n || exp_q.size() != 0); cyc++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            s_valid = (sent < n) && ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom);
            #1;
            check("rs_m_valid", m_valid, (exp_q.size() != 0));
            check("rs_s_ready", s_ready, (exp_q.size() == 0) || m_ready);
            if (m_valid && exp_q.size() != 0) begin
                check("rs_m_data", m_data, exp_q[0]);
                if (m_ready) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(model_inv[s_data]);
                sent++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("rs_all_sent", sent, n);
        check("rs_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cur_kind;

        reset      = 1'b1;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        for (int i = 0; i < N; i++) model_inv[i] = '0;
        model_clear();

        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("post_reset");

        // constant vectors: kind 0 = identity load, kind 1 = reverse load
        vecs[0] = '{0, 8'h00, 8'h00};
        vecs[1] = '{0, 8'h7F, 8'h7F};
        vecs[2] = '{0, 8'hFF, 8'hFF};
        vecs[3] = '{1, 8'h00, 8'hFF};
        vecs[4] = '{1, 8'h01, 8'hFE};
        cur_kind = -1;
        foreach (vecs[i]) begin
            if (vecs[i].kind != cur_kind) begin
                if (cur_kind != -1) do_clear();
                if (vecs[i].kind == 0) fill_identity();
                else fill_reverse();
                run_load();
                cur_kind = vecs[i].kind;
            end
            lookup_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
        end

        // backpressure on the reverse table: inv[5]=FA, inv[6]=F9
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h05;
        m_ready = 1'b0;
        @(negedge clk);
        s_data = 8'h06;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_s_ready_low", s_ready, 0);
            check("bp_m_valid_hold", m_valid, 1);
            check("bp_m_data_hold", m_data, 8'hFA);
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        check("bp_release_s_ready", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        check("bp_second_valid", m_valid, 1);
        check("bp_second_data", m_data, 8'hF9);
        @(negedge clk);
        check("bp_no_dup", m_valid, 0);

        random_stream(60);

        // duplicate value offered during LOAD
        do_clear();
        load_q.delete();
        load_q.push_back(8'h10);
        load_q.push_back(8'h10);
        for (int i = 0; i < N; i++) if (i != 'h10) load_q.push_back(8'(i));
        run_load();
        lookup_one("dup_inv10", 8'h10, 8'h00);
        lookup_one("dup_inv00", 8'h00, 8'h01);
        lookup_one("dup_inv11", 8'h11, 8'h11);

        // clear while m_valid is held, with a competing load beat
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h20;
        m_ready = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        check("clr_pre_m_valid", m_valid, 1);
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h33;
        @(negedge clk);
        clear      = 1'b0;
        load_valid = 1'b0;
        m_ready    = 1'b1;
        model_clear();
        check("clr_table_ready", table_ready, 0);
        check("clr_m_valid", m_valid, 0);
        check("clr_load_count", load_count, 0);
        check("clr_dup_err", dup_err, 0);
        check("clr_s_ready", s_ready, 0);
        fill_random();
        run_load();
        random_stream(80);

        // asynchronous reset after 100 beats
        fill_random();
        load_q = load_q[0:99];
        run_load();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_inv[i] = '0;
        model_clear();
        fill_random();
        run_load();
        random_stream(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
